// File: rtl/lsu_dmem_port_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_dmem_port_if
// Description : Data-memory request bus between the load/store unit and the
//               data memory. Req/gnt handshake for the address phase, then an
//               rvalid-qualified read data phase.
//               master : LSU side  (drives req/we/addr/wdata/wstrb)
//               slave  : memory side (drives gnt/rvalid/rdata)
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_dmem_port_if #(
    parameter int ADDR_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [3:0]        dmem_wstrb;
    logic              dmem_gnt;
    logic              dmem_rvalid;
    logic [31:0]       dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_dmem_port.sv
`default_nettype none
// ============================================================================
// Module      : lsu_dmem_port
// Description : Responder side of the decode-stage memory stall handshake.
//               Accepts loads (op 0000011) and stores (op 0100011) from
//               decode, runs one access on the data-memory bus, and returns a
//               one-cycle completion pulse. Performs byte-lane steering,
//               write-strobe generation and load sign/zero extension.
// Ports       : clk, reset (async, active-high)
//               op/funct3/addr/store_data   - instruction from decode
//               mem_read_data_valid         - load complete pulse
//               mem_write_ready             - store complete pulse
//               load_data                   - formatted load result (held)
//               misaligned                  - misalignment trap pulse
//               dmem                        - data-memory bus (master)
// Options     : LSU_MISALIGN_TRAP_EN - when defined, misaligned halfword/word
//               accesses complete immediately with misaligned=1 and never
//               reach memory; otherwise low address bits are truncated.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_dmem_port #(
    parameter int ADDR_W = 32
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic [6:0]        op,
    input  wire logic [2:0]        funct3,
    input  wire logic [ADDR_W-1:0] addr,
    input  wire logic [31:0]       store_data,
    output logic                   mem_read_data_valid,
    output logic                   mem_write_ready,
    output logic [31:0]            load_data,
    output logic                   misaligned,
    lsu_dmem_port_if.master        dmem
);

    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;

    localparam logic [1:0] c_SZ_BYTE = 2'd0;
    localparam logic [1:0] c_SZ_HALF = 2'd1;
    localparam logic [1:0] c_SZ_WORD = 2'd2;

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_REQ     = 3'd1;
    localparam logic [2:0] c_WAIT_R  = 3'd2;
    localparam logic [2:0] c_LD_DONE = 3'd3;
    localparam logic [2:0] c_ST_DONE = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;

    logic              r_is_store;
    logic [2:0]        r_funct3;
    logic [1:0]        r_byte_off;
    logic [ADDR_W-1:0] r_word_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [31:0]       r_load_data;

    logic              w_is_load;
    logic              w_is_store;
    logic              w_issue;
    logic [1:0]        w_size;
    logic [3:0]        w_wstrb;
    logic [31:0]       w_wdata;
    logic [1:0]        w_ld_size;
    logic [7:0]        w_ld_byte;
    logic [15:0]       w_ld_half;
    logic [31:0]       w_load_fmt;
    logic              w_trap;

    assign w_is_load  = (op == c_OP_LOAD);
    assign w_is_store = (op == c_OP_STORE);
    assign w_issue    = w_is_load | w_is_store;

    // Access size of the incoming instruction. Stores only recognise SB/SH,
    // everything else is a full word; loads use funct3[2] as the unsigned
    // flag so only the low two bits pick the size.
    always_comb begin
        w_size = c_SZ_WORD;
        if (w_is_store) begin
            case (funct3)
                3'b000:  w_size = c_SZ_BYTE;
                3'b001:  w_size = c_SZ_HALF;
                default: w_size = c_SZ_WORD;
            endcase
        end else begin
            case (funct3[1:0])
                2'b00:   w_size = c_SZ_BYTE;
                2'b01:   w_size = c_SZ_HALF;
                default: w_size = c_SZ_WORD;
            endcase
        end
    end

    // Store data is replicated across all lanes so the strobe alone selects
    // the destination bytes.
    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = store_data;
        case (w_size)
            c_SZ_BYTE: begin
                w_wstrb = 4'b0001 << addr[1:0];
                w_wdata = {4{store_data[7:0]}};
            end
            c_SZ_HALF: begin
                w_wstrb = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{store_data[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = store_data;
            end
        endcase
    end

    // Load formatting works from the captured offset/funct3 so it stays
    // correct however long the memory takes to return data.
    assign w_ld_size = r_funct3[1:0];

    always_comb begin
        w_ld_byte = dmem.dmem_rdata[7:0];
        case (r_byte_off)
            2'd0:    w_ld_byte = dmem.dmem_rdata[7:0];
            2'd1:    w_ld_byte = dmem.dmem_rdata[15:8];
            2'd2:    w_ld_byte = dmem.dmem_rdata[23:16];
            default: w_ld_byte = dmem.dmem_rdata[31:24];
        endcase
        w_ld_half = r_byte_off[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (w_ld_size)
            2'b00:   w_load_fmt = {{24{w_ld_byte[7] & ~r_funct3[2]}}, w_ld_byte};
            2'b01:   w_load_fmt = {{16{w_ld_half[15] & ~r_funct3[2]}}, w_ld_half};
            default: w_load_fmt = dmem.dmem_rdata;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_misaligned;

    always_comb begin
        w_trap = 1'b0;
        case (w_size)
            c_SZ_HALF: w_trap = w_issue & addr[0];
            c_SZ_WORD: w_trap = w_issue & (addr[1:0] != 2'b00);
            default:   w_trap = 1'b0;
        endcase
    end

    assign misaligned = r_misaligned & ((r_state == c_LD_DONE) | (r_state == c_ST_DONE));
`else
    assign w_trap     = 1'b0;
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_issue) begin
                    // A trapped access completes without touching memory.
                    if (w_trap) begin
                        w_next_state = w_is_store ? c_ST_DONE : c_LD_DONE;
                    end else begin
                        w_next_state = c_REQ;
                    end
                end
            end
            c_REQ: begin
                if (dmem.dmem_gnt) begin
                    w_next_state = r_is_store ? c_ST_DONE : c_WAIT_R;
                end
            end
            c_WAIT_R: begin
                if (dmem.dmem_rvalid) begin
                    w_next_state = c_LD_DONE;
                end
            end
            c_LD_DONE: w_next_state = c_IDLE;
            c_ST_DONE: w_next_state = c_IDLE;
            default:   w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_store  <= 1'b0;
            r_funct3    <= 3'b000;
            r_byte_off  <= 2'b00;
            r_word_addr <= '0;
            r_wdata     <= 32'h0;
            r_wstrb     <= 4'h0;
            r_load_data <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_misaligned <= 1'b0;
`endif
        end else begin
            if ((r_state == c_IDLE) && w_issue) begin
                r_is_store  <= w_is_store;
                r_funct3    <= funct3;
                r_byte_off  <= addr[1:0];
                r_word_addr <= {addr[ADDR_W-1:2], 2'b00};
                r_wdata     <= w_wdata;
                r_wstrb     <= w_wstrb;
`ifdef LSU_MISALIGN_TRAP_EN
                r_misaligned <= w_trap;
                if (w_trap && w_is_load) begin
                    r_load_data <= 32'h0;
                end
`endif
            end
            if ((r_state == c_WAIT_R) && dmem.dmem_rvalid) begin
                r_load_data <= w_load_fmt;
            end
        end
    end

    // Bus control and completion pulses decode straight from state so that
    // an asynchronous reset removes them immediately.
    assign dmem.dmem_req   = (r_state == c_REQ);
    assign dmem.dmem_we    = (r_state == c_REQ) & r_is_store;
    assign dmem.dmem_addr  = r_word_addr;
    assign dmem.dmem_wdata = r_wdata;
    assign dmem.dmem_wstrb = r_wstrb;

    assign mem_read_data_valid = (r_state == c_LD_DONE);
    assign mem_write_ready     = (r_state == c_ST_DONE);
    assign load_data           = r_load_data;

endmodule
`default_nettype wire
